// File: rtl/weight_loader_3x3_pkg.sv
// weight_loader_3x3_pkg: shared widths and kernel-group helper for the 3x3 weight loader
package weight_loader_3x3_pkg;
    localparam int AXI_WIDTH_DATA_IN = 128;
    localparam int WL_KERNEL_NUM = 9;
    localparam int WL_ADDR_W = 13;
    localparam int KPOS_W = 4;
    function automatic logic [1:0] group_of(input logic [KPOS_W-1:0] k);
        return k < 4'd3 ? 2'd0 : k < 4'd6 ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/weight_pos_counter.sv
// weight_pos_counter: nested kernel-position (0..8) / row (0..depth-1) counter with last-beat flag
module weight_pos_counter
    import weight_loader_3x3_pkg::*;
#(
    parameter int ADDR_W = WL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ADDR_W-1:0] depth,
    output logic [KPOS_W-1:0] k,
    output logic [ADDR_W-1:0] r,
    output logic              last
);
    logic [KPOS_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] r_q, r_d;
    always_comb begin
        k_d = clr ? '0 : en ? (k_q == 4'd8 ? '0 : k_q + 4'd1) : k_q;
        r_d = clr ? '0 : (en && k_q == 4'd8) ? r_q + ADDR_W'(1) : r_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            r_q <= '0;
        end else begin
            k_q <= k_d;
            r_q <= r_d;
        end
    end
    assign k = k_q;
    assign r = r_q;
    assign last = k_q == 4'd8 && r_q == depth - ADDR_W'(1);
endmodule

// File: rtl/weight_loader_3x3.sv
// weight_loader_3x3: steers a weight word stream into the nine 3x3 kernel-position RAMs
module weight_loader_3x3
    import weight_loader_3x3_pkg::*;
#(
    parameter int KERNEL_NUM = WL_KERNEL_NUM,
    parameter int DATA_W = AXI_WIDTH_DATA_IN,
    parameter int ADDR_W = WL_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     depth,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     weight_data_One,
    output logic [DATA_W-1:0]     weight_data_Two,
    output logic [DATA_W-1:0]     weight_data_Three,
    output logic [KERNEL_NUM-1:0] weight_wr,
    output logic [ADDR_W-1:0]     weight_addra,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] depth_q, depth_d, base_q, base_d, addr_q, addr_d, row;
    logic [KERNEL_NUM-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] one_q, one_d, two_q, two_d, three_q, three_d;
    logic [KPOS_W-1:0] kpos;
    logic [1:0] grp;
    logic beat, last, clr;

    weight_pos_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (beat),
        .depth(depth_q),
        .k    (kpos),
        .r    (row),
        .last (last)
    );

    assign s_ready = state_q == LOAD;
    assign beat = s_ready & s_valid;
    assign busy = state_q == LOAD || state_q == FLUSH;
    assign done = state_q == FLUSH || state_q == DONE;

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        base_d = base_q;
        clr = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = depth == '0 ? DONE : LOAD;
                depth_d = depth;
                base_d = base_addr;
                clr = 1'b1;
            end
            LOAD: state_d = beat && last ? FLUSH : LOAD;
            default: state_d = IDLE;
        endcase
        // one registered write per accepted beat; unselected buses hold
        grp = group_of(kpos);
        wr_d = beat ? KERNEL_NUM'(1) << kpos : '0;
        addr_d = beat ? base_q + row : addr_q;
        one_d = beat && grp == 2'd0 ? s_data : one_q;
        two_d = beat && grp == 2'd1 ? s_data : two_q;
        three_d = beat && grp == 2'd2 ? s_data : three_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            depth_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            wr_q <= '0;
            one_q <= '0;
            two_q <= '0;
            three_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            base_q <= base_d;
            addr_q <= addr_d;
            wr_q <= wr_d;
            one_q <= one_d;
            two_q <= two_d;
            three_q <= three_d;
        end
    end

    assign weight_wr = wr_q;
    assign weight_addra = addr_q;
    assign weight_data_One = one_q;
    assign weight_data_Two = two_q;
    assign weight_data_Three = three_q;
endmodule

// File: tb/tb_weight_loader_3x3.sv
// tb_weight_loader_3x3: randomized stream loads checked against an ordered write-list model
module tb_weight_loader_3x3;
    localparam int AW = 13;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst, start, s_valid, s_ready, busy, done;
    logic [AW-1:0] depth, base_addr, weight_addra;
    logic [DW-1:0] s_data, weight_data_One, weight_data_Two, weight_data_Three;
    logic [8:0] weight_wr;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [8:0] wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] b0, b1, b2;
        logic done, busy, rdy;
    } obs_t;
    typedef struct {
        logic [8:0] wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] b0, b1, b2;
    } exp_t;

    obs_t log_q[$];
    exp_t exp_q[$];
    logic [DW-1:0] mdl_bus [3];

    weight_loader_3x3 dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .depth            (depth),
        .base_addr        (base_addr),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .weight_data_One  (weight_data_One),
        .weight_data_Two  (weight_data_Two),
        .weight_data_Three(weight_data_Three),
        .weight_wr        (weight_wr),
        .weight_addra     (weight_addra),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.wr = weight_wr;
        o.addr = weight_addra;
        o.b0 = weight_data_One;
        o.b1 = weight_data_Two;
        o.b2 = weight_data_Three;
        o.done = done;
        o.busy = busy;
        o.rdy = s_ready;
        return o;
    endfunction

    // Builds the expected write list (word i -> position i%9, row i/9), then pulses start and
    // streams the words; mode 0 = valid always, 1 = every other cycle, 2 = random.
    // log_q[c] holds outputs seen c+1 cycles after the start edge.
    task automatic drive_load(input int d, input logic [AW-1:0] b, input int mode, input bit a5, input int max_cyc);
        logic [DW-1:0] words[$];
        int n;
        int idx;
        bit v;
        exp_t e;
        n = 9 * d;
        idx = 0;
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = {$urandom, $urandom, $urandom, $urandom};
            if (a5 && i == 4) w = {16{8'hA5}};
            words.push_back(w);
            mdl_bus[(i % 9) / 3] = w;
            e.wr = 9'b1 << (i % 9);
            e.addr = AW'((int'(b) + i / 9) % 8192);
            e.b0 = mdl_bus[0];
            e.b1 = mdl_bus[1];
            e.b2 = mdl_bus[2];
            exp_q.push_back(e);
        end
        start = 1'b1;
        depth = AW'(d);
        base_addr = b;
        s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            log_q.push_back(sample());
            v = idx < n && (mode == 0 || (mode == 1 && c % 2 == 0) ||
                            (mode == 2 && ($urandom_range(2) != 0 || c >= 3 * n)));
            s_valid = v;
            s_data = v ? words[idx] : {$urandom, $urandom, $urandom, $urandom};
            if (v && s_ready) idx++;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (weight_wr !== 9'h0 || weight_addra !== 13'h0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: wr=%h addr=%h rdy=%b, expected 000 0000 0", weight_wr, weight_addra, s_ready);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: busy=%b done=%b, expected 0 0", busy, done);
        end
        n_cmp++;
        if ({weight_data_One, weight_data_Two, weight_data_Three} !== '0) begin
            n_err++;
            $display("FAIL reset_buses: %h %h %h, expected zero", weight_data_One, weight_data_Two, weight_data_Three);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_rows();
        drive_load(2, 13'h0, 0, 1'b1, 24);
        for (int i = 0; i < 18; i++) begin
            obs_t o;
            o = log_q[i + 1];
            n_cmp++;
            if (o.wr !== exp_q[i].wr || o.addr !== exp_q[i].addr) begin
                n_err++;
                $display("FAIL full_rows_wr[%0d]: wr=%h addr=%h, expected wr=%h addr=%h", i, o.wr, o.addr, exp_q[i].wr, exp_q[i].addr);
            end
            n_cmp++;
            if ({o.b0, o.b1, o.b2} !== {exp_q[i].b0, exp_q[i].b1, exp_q[i].b2}) begin
                n_err++;
                $display("FAIL full_rows_bus[%0d]: got %h, expected %h", i, {o.b0, o.b1, o.b2}, {exp_q[i].b0, exp_q[i].b1, exp_q[i].b2});
            end
        end
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if (log_q[c].done !== (c == 18) || log_q[c].busy !== (c <= 18)) begin
                n_err++;
                $display("FAIL full_rows_status[%0d]: done=%b busy=%b, expected %b %b", c, log_q[c].done, log_q[c].busy, c == 18, c <= 18);
            end
        end
        n_cmp++;
        if (log_q[18].rdy !== 1'b0 || log_q[0].wr !== 9'h0) begin
            n_err++;
            $display("FAIL full_rows_edges: rdy@done=%b wr@first=%h, expected 0 000", log_q[18].rdy, log_q[0].wr);
        end
        n_cmp++;
        if (log_q[5].wr !== 9'h010 || log_q[5].b1 !== {16{8'hA5}}) begin
            n_err++;
            $display("FAIL routing_a5: wr=%h two=%h, expected 010 and A5 pattern", log_q[5].wr, log_q[5].b1);
        end
    endtask

    task automatic test_stall();
        drive_load(1, AW'($urandom), 1, 1'b0, 22);
        for (int c = 0; c < 22; c++) begin
            logic [8:0] ew;
            ew = (c % 2 == 1 && c <= 17) ? exp_q[c / 2].wr : 9'h0;
            n_cmp++;
            if (log_q[c].wr !== ew || log_q[c].done !== (c == 17)) begin
                n_err++;
                $display("FAIL stall[%0d]: wr=%h done=%b, expected wr=%h done=%b", c, log_q[c].wr, log_q[c].done, ew, c == 17);
            end
        end
    endtask

    task automatic test_wrap();
        drive_load(3, 13'h1FFF, 0, 1'b0, 32);
        for (int i = 0; i < 27; i++) begin
            n_cmp++;
            if (log_q[i + 1].wr !== exp_q[i].wr || log_q[i + 1].addr !== exp_q[i].addr) begin
                n_err++;
                $display("FAIL wrap[%0d]: wr=%h addr=%h, expected wr=%h addr=%h", i, log_q[i + 1].wr, log_q[i + 1].addr, exp_q[i].wr, exp_q[i].addr);
            end
        end
        n_cmp++;
        if (log_q[1].addr !== 13'h1FFF || log_q[10].addr !== 13'h0000 || log_q[19].addr !== 13'h0001) begin
            n_err++;
            $display("FAIL wrap_rows: %h %h %h, expected 1fff 0000 0001", log_q[1].addr, log_q[10].addr, log_q[19].addr);
        end
    endtask

    task automatic test_zero_depth();
        int dn;
        dn = 0;
        drive_load(0, AW'($urandom), 0, 1'b0, 8);
        for (int c = 0; c < 8; c++) begin
            if (log_q[c].done === 1'b1) dn++;
            n_cmp++;
            if (log_q[c].wr !== 9'h0 || log_q[c].busy !== 1'b0) begin
                n_err++;
                $display("FAIL zero_depth[%0d]: wr=%h busy=%b, expected 000 0", c, log_q[c].wr, log_q[c].busy);
            end
        end
        n_cmp++;
        if (dn != 1 || log_q[0].done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_depth_done: pulses=%0d first=%b, expected 1 1", dn, log_q[0].done);
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            int d, n, w, dn;
            d = $urandom_range(4, 1);
            n = 9 * d;
            w = 0;
            dn = 0;
            drive_load(d, AW'($urandom), 2, 1'b0, 4 * n + 20);
            foreach (log_q[c]) begin
                if (log_q[c].wr !== 9'h0) begin
                    n_cmp++;
                    if (w >= n) begin
                        n_err++;
                        $display("FAIL b2b_extra: load %0d cycle %0d wr=%h, expected no write", it, c, log_q[c].wr);
                    end else if (log_q[c].wr !== exp_q[w].wr || log_q[c].addr !== exp_q[w].addr ||
                                 {log_q[c].b0, log_q[c].b1, log_q[c].b2} !== {exp_q[w].b0, exp_q[w].b1, exp_q[w].b2}) begin
                        n_err++;
                        $display("FAIL b2b_write: load %0d write %0d wr=%h addr=%h, expected wr=%h addr=%h (or bus)", it, w, log_q[c].wr, log_q[c].addr, exp_q[w].wr, exp_q[w].addr);
                    end
                    w++;
                end
                if (log_q[c].done === 1'b1) begin
                    dn++;
                    n_cmp++;
                    if (w != n || log_q[c].wr === 9'h0 || log_q[c].rdy !== 1'b0) begin
                        n_err++;
                        $display("FAIL b2b_done: load %0d writes=%0d wr=%h rdy=%b, expected %0d nonzero 0", it, w, log_q[c].wr, log_q[c].rdy, n);
                    end
                end
            end
            n_cmp++;
            if (w != n || dn != 1) begin
                n_err++;
                $display("FAIL b2b_count: load %0d writes=%0d dones=%0d, expected %0d 1", it, w, dn, n);
            end
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        depth = 13'd4;
        base_addr = 13'h0010;
        s_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = {$urandom, $urandom, $urandom, $urandom};
            start = i == 2;
            if (i == 2) begin
                depth = 13'd1;
                base_addr = 13'h0000;
            end
            @(negedge clk);
            n_cmp++;
            if (weight_wr !== 9'b1 << i || weight_addra !== 13'h0010 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL mid_start[%0d]: wr=%h addr=%h busy=%b, expected %h 0010 1", i, weight_wr, weight_addra, busy, 9'b1 << i);
            end
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (weight_wr !== 9'h0 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || weight_addra !== 13'h0) begin
            n_err++;
            $display("FAIL rst_mid: wr=%h rdy=%b busy=%b done=%b addr=%h, expected all zero", weight_wr, s_ready, busy, done, weight_addra);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        foreach (mdl_bus[g]) mdl_bus[g] = '0;
        drive_load(1, AW'($urandom), 0, 1'b0, 14);
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (log_q[i + 1].wr !== exp_q[i].wr || log_q[i + 1].addr !== exp_q[i].addr ||
                {log_q[i + 1].b0, log_q[i + 1].b1, log_q[i + 1].b2} !== {exp_q[i].b0, exp_q[i].b1, exp_q[i].b2}) begin
                n_err++;
                $display("FAIL reload[%0d]: wr=%h addr=%h, expected wr=%h addr=%h (or bus)", i, log_q[i + 1].wr, log_q[i + 1].addr, exp_q[i].wr, exp_q[i].addr);
            end
        end
        n_cmp++;
        if (log_q[9].done !== 1'b1 || log_q[10].busy !== 1'b0) begin
            n_err++;
            $display("FAIL reload_done: done=%b busy_after=%b, expected 1 0", log_q[9].done, log_q[10].busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        depth = '0;
        base_addr = '0;
        foreach (mdl_bus[g]) mdl_bus[g] = '0;
        test_reset();
        test_full_rows();
        test_stall();
        test_wrap();
        test_zero_depth();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
